// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - round-robin packet-locked output arbiter for one NoC router output port
// Optional per-port grant counters: define ARB_GRANT_STATS_EN.
module noc_output_arbiter #(
  parameter int NPORTS    = 5,
  parameter int FLIT_W    = 16,
  parameter int PKT_FLITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_i,
  input  logic [NPORTS-1:0]        nempty_i,
  input  logic [NPORTS*FLIT_W-1:0] data_i,
  input  logic                     ready_i,
  output logic [NPORTS-1:0]        pop_o,
  output logic [NPORTS-1:0]        grant_o,
  output logic [FLIT_W-1:0]        data_o,
  output logic                     valid_o,
  output logic                     busy_o
`ifdef ARB_GRANT_STATS_EN
  ,
  output logic [NPORTS*16-1:0]     grant_cnt_o
`endif
);

  localparam int CNT_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [CNT_W-1:0] flit_cnt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] winner;
  logic             found;
  logic             fire;
  int               sel_idx;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    sel_idx = 0;
    for (int i = 0; i < NPORTS; i++) begin
      sel_idx = int'(rr_ptr) + i;
      if (sel_idx >= NPORTS) sel_idx = sel_idx - NPORTS;
      if (!found && req_i[sel_idx]) begin
        winner = PTR_W'(sel_idx);
        found  = 1'b1;
      end
    end
  end

  // Output path is combinational off the registered owner so a pop lands in the accept cycle.
  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    pop_o   = '0;
    fire    = 1'b0;
    if (state == XFER) begin
      data_o  = data_i[owner*FLIT_W +: FLIT_W];
      valid_o = nempty_i[owner];
      fire    = nempty_i[owner] && ready_i;
      if (fire) pop_o = grant_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_o  <= '0;
      owner    <= '0;
      flit_cnt <= '0;
      rr_ptr   <= '0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_o  <= NPORTS'(1) << winner;
            owner    <= winner;
            flit_cnt <= '0;
            busy_o   <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if (fire) begin
            if (flit_cnt == CNT_W'(PKT_FLITS - 1)) begin
              state    <= IDLE;
              grant_o  <= '0;
              busy_o   <= 1'b0;
              flit_cnt <= '0;
              rr_ptr   <= (owner == PTR_W'(NPORTS - 1)) ? '0 : owner + 1'b1;
            end else begin
              flit_cnt <= flit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_GRANT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_o <= '0;
    end else if (state == IDLE && found &&
                 grant_cnt_o[winner*16 +: 16] != 16'hFFFF) begin
      grant_cnt_o[winner*16 +: 16] <= grant_cnt_o[winner*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - directed self-checking bench for noc_output_arbiter
module tb_noc_output_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_i;
  logic [4:0]  nempty_i;
  logic [79:0] data_i;
  logic        ready_i;
  logic [4:0]  pop_o;
  logic [4:0]  grant_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        busy_o;
`ifdef ARB_GRANT_STATS_EN
  logic [79:0] grant_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  noc_output_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .nempty_i (nempty_i),
    .data_i   (data_i),
    .ready_i  (ready_i),
    .pop_o    (pop_o),
    .grant_o  (grant_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
`ifdef ARB_GRANT_STATS_EN
    ,
    .grant_cnt_o (grant_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    req_i    = '0;
    nempty_i = '0;
    ready_i  = 1'b0;
    for (int k = 0; k < 5; k++) data_i[k*16 +: 16] = 16'hC0D0 + 16'(k);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy",  busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_pop",   pop_o, 0);
    chk("rst_data",  data_o, 0);
    rst = 1'b0;

    // single requester on port 2
    req_i = 5'b00100; nempty_i = 5'b00100; ready_i = 1'b1;
    #1;
    chk("t1_pre_grant", grant_o, 0);
    tick();
    chk("t1_grant", grant_o, 5'b00100);
    chk("t1_busy",  busy_o, 1);
    req_i = '0;
    for (int f = 0; f < 5; f++) begin
      chk("t1_pop",   pop_o, 5'b00100);
      chk("t1_data",  data_o, 16'hC0D2);
      chk("t1_valid", valid_o, 1);
      tick();
    end
    chk("t1_rel_grant", grant_o, 0);
    chk("t1_rel_busy",  busy_o, 0);
    chk("t1_rel_pop",   pop_o, 0);
    chk("t1_rel_data",  data_o, 0);

    // pointer is 3: port 4 must beat port 2
    req_i = 5'b10100; nempty_i = 5'b10100;
    tick();
    chk("ptr_grant", grant_o, 5'b10000);
    req_i = '0;
    repeat (5) tick();
    chk("ptr_rel", grant_o, 0);

    // all requesting; pointer wrapped to 0
    req_i = 5'b11111; nempty_i = 5'b11111;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("rr_grant", grant_o, 32'(5'b00001 << (g % 5)));
      chk("rr_data",  data_o, 32'(16'hC0D0 + 16'(g % 5)));
      for (int f = 0; f < 5; f++) begin
        chk("rr_pop", pop_o, 32'(5'b00001 << (g % 5)));
        tick();
      end
      chk("rr_gap", grant_o, 0);
    end
    req_i = '0;

    // backpressure on port 1 (pointer now 1)
    req_i = 5'b00010; nempty_i = 5'b00010; ready_i = 1'b1;
    tick();
    chk("bp_grant", grant_o, 5'b00010);
    req_i = '0;
    pops = 0;
    if (pop_o[1]) pops++;
    tick();
    ready_i = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("bp_stall_pop",   pop_o, 0);
      chk("bp_stall_valid", valid_o, 1);
      chk("bp_stall_grant", grant_o, 5'b00010);
      tick();
    end
    ready_i = 1'b1;
    #1;
    for (int f = 0; f < 4; f++) begin
      chk("bp_hold", grant_o, 5'b00010);
      if (pop_o[1]) pops++;
      tick();
    end
    chk("bp_pops", pops, 5);
    chk("bp_rel",  grant_o, 0);

    // starved queue on port 3
    req_i = 5'b01000; nempty_i = 5'b01000;
    tick();
    chk("st_grant", grant_o, 5'b01000);
    req_i = '0;
    repeat (2) tick();
    nempty_i = '0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("st_valid", valid_o, 0);
      chk("st_pop",   pop_o, 0);
      chk("st_grant_hold", grant_o, 5'b01000);
      tick();
    end
    nempty_i = 5'b01000;
    #1;
    for (int f = 0; f < 3; f++) begin
      chk("st_resume_pop", pop_o, 5'b01000);
      tick();
    end
    chk("st_rel",  grant_o, 0);
    chk("st_busy", busy_o, 0);

    // reset mid-packet on port 4
    req_i = 5'b10000; nempty_i = 5'b10000;
    tick();
    chk("mr_grant", grant_o, 5'b10000);
    req_i = '0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("mr_grant_clr", grant_o, 0);
    chk("mr_pop_clr",   pop_o, 0);
    chk("mr_valid_clr", valid_o, 0);
    chk("mr_busy_clr",  busy_o, 0);
    req_i = 5'b10001; nempty_i = 5'b10001;
    tick();
    rst = 1'b0;
    tick();
    chk("mr_first_grant", grant_o, 5'b00001);
    req_i = '0;
    repeat (5) tick();

`ifdef ARB_GRANT_STATS_EN
    rst = 1'b1;
    #1;
    rst = 1'b0;
    checks++;
    assert (grant_cnt_o === 80'd0) else begin
      errors++;
      $error("FAIL stats_rst: observed %h expected 0", grant_cnt_o);
    end
    for (int p = 0; p < 4; p++) begin
      req_i = (p == 3) ? 5'b00100 : 5'b00001;
      nempty_i = req_i;
      tick();
      req_i = '0;
      repeat (5) tick();
    end
    checks++;
    assert (grant_cnt_o === {16'd0, 16'd0, 16'd1, 16'd0, 16'd3}) else begin
      errors++;
      $error("FAIL stats_cnt: observed %h expected %h", grant_cnt_o,
             {16'd0, 16'd0, 16'd1, 16'd0, 16'd3});
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Round-robin, packet-locked arbiter for one output port of the 5-port NoC router.
- Shares the output link among the 5 input queues: picks one requesting queue, holds the grant for a full packet, pops its flits in order, then releases.
- One instance per output port; sits between the input queues' head/pop interface and the output link.

Parameters:
- NPORTS, 5, number of input queues competing for this output.
- FLIT_W, 16, flit width in bits.
- PKT_FLITS, 5, flits per packet (fixed-length packets).

Ports:
- clk  in  1  router clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NPORTS  bit k: head flit of queue k is a packet header routed to this output.
- nempty_i  in  NPORTS  bit k: queue k holds at least one flit.
- data_i  in  NPORTS*FLIT_W  head flits; queue k occupies bits [k*FLIT_W +: FLIT_W].
- ready_i  in  1  downstream link accepts a flit this cycle.
- pop_o  out  NPORTS  one-hot, active-high; one pulse per flit popped from queue k.
- grant_o  out  NPORTS  one-hot owner of the output; 0 when idle.
- data_o  out  FLIT_W  selected head flit; 0 when no grant.
- valid_o  out  1  data_o is a valid flit.
- busy_o  out  1  a packet is in flight (state XFER).

Behaviour:
- Reset (async, immediate): state IDLE, grant_o=0, flit count=0, RR pointer=0, pop_o=0, valid_o=0, data_o=0, busy_o=0.
- FSM states:
  - IDLE: if req_i != 0, register the winner into grant_o, clear the flit count, go to XFER. Otherwise stay. One cycle from req_i seen to grant_o asserted.
  - XFER: owner is k. valid_o = nempty_i[k]. data_o = data_i slice k (combinational mux).
- Transfer: when valid_o && ready_i, pop_o[k]=1 in the same cycle and the flit count increments.
- No flit pops when nempty_i[k]=0 or ready_i=0. Grant and count are held; no timeout.
- Release: on the pop where count == PKT_FLITS-1, go to IDLE, clear grant_o, set RR pointer = (k+1) mod NPORTS.
- Every packet therefore has one IDLE bubble cycle before the next grant.
- Arbitration: search starts at the RR pointer and proceeds upward with wrap. First set req_i bit wins.
- req_i is sampled only in IDLE. Changes to req_i, or to other ports' inputs, during XFER are ignored.
- The flit counter is a clog2(PKT_FLITS)-bit counter that never exceeds PKT_FLITS-1.
- The RR pointer is a clog2(NPORTS)-bit counter that wraps from NPORTS-1 to 0.
- Pops are exactly PKT_FLITS per grant; the queue's own packet framing is not re-checked.
- If rst asserts mid-packet, the partial packet is abandoned and all outputs clear immediately. Draining the queues is the system reset's responsibility.
- pop_o is only ever nonzero in XFER and is always a subset of grant_o.

Optional Feature:
- Macro ARB_GRANT_STATS_EN.
- Defined:
  - Adds output port grant_cnt_o (NPORTS*16): a per-port 16-bit saturating count of packets granted.
  - A port's count increments on the IDLE->XFER transition that grants that port.
  - Counts clear on rst and saturate at 16'hFFFF.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester: req_i=5'b00100, nempty_i=5'b00100, ready_i=1. Response:
  - grant_o=5'b00100 one cycle later.
  - pop_o[2] asserted 5 consecutive cycles; data_o tracks data_i[47:32].
  - Then IDLE with grant_o=0; next pointer=3.
- All request after reset: req_i=5'b11111 held, all nempty. Response:
  - Grant order 0,1,2,3,4,0.
  - Each grant lasts 5 pops; one-cycle IDLE gap between grants.
- Backpressure: port 1 granted, ready_i=0 for cycles 2-4 of the packet. Response:
  - pop_o=0 and valid_o=1 while stalled.
  - Total pops remain 5; release only after the 5th pop.
- Starved queue: port 3 granted, nempty_i[3] drops after 2 pops for 3 cycles. Response:
  - valid_o=0, no pops, grant held.
  - Resumes, completing 3 more pops.
- Reset mid-packet: assert rst after 2 pops of port 4. Response:
  - grant_o, pop_o, valid_o, busy_o=0 without waiting for a clock edge.
  - With req_i=5'b10001, the first grant after reset goes to port 0.
- ARB_GRANT_STATS_EN: 3 packets via port 0 and 1 via port 2. Response: grant_cnt_o shows port0=3, port2=1, others 0.
